// File: rtl/serial_full_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives the operands and start pulse; the subtractor returns
// status and the registered result.
interface serial_full_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out
  );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per cycle, LSB first.
// A single full-subtractor cell plus a borrow flop walk the operands over
// WIDTH cycles. The result registers change only on entering DONE, so the
// previous answer stays visible while the next operation shifts.
module serial_full_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_full_subtractor_if.slave  bus
);

  // A counter of at least one bit keeps WIDTH=1 legal.
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] dsr;
  logic             br;
  logic [CW-1:0]    count;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             x;
  logic             y;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] dsr_nxt;
  logic [WIDTH-1:0] ra_nxt;
  logic [WIDTH-1:0] rb_nxt;
  logic             last;

  // Full-subtractor cell on the current LSBs, plus next-state of the shifters
  always_comb begin
    x      = ra[0];
    y      = rb[0];
    d      = x ^ y ^ br;
    br_nxt = (~x & y) | (~(x ^ y) & br);
    // Written as shift-then-insert so a one-bit width needs no special slice.
    dsr_nxt            = dsr >> 1;
    dsr_nxt[WIDTH-1]   = d;
    ra_nxt             = ra >> 1;
    rb_nxt             = rb >> 1;
    last               = (count == CW'(WIDTH - 1));
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ra     <= '0;
      rb     <= '0;
      dsr    <= '0;
      br     <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra     <= bus.a;
            rb     <= bus.b;
            br     <= bus.b_in;
            count  <= '0;
            dsr    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          dsr   <= dsr_nxt;
          ra    <= ra_nxt;
          rb    <= rb_nxt;
          br    <= br_nxt;
          count <= count + 1'b1;
          if (last) begin
            diff_q <= dsr_nxt;
            bout_q <= br_nxt;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor: an 8-bit and a 1-bit instance
// share clock and reset; each scenario task checks its own expectations.
module tb_serial_full_subtractor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_full_subtractor_if #(.WIDTH(8)) bus8();
  serial_full_subtractor_if #(.WIDTH(1)) bus1();

  serial_full_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_full_subtractor #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for one edge, then scramble the inputs
  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    @(negedge clk);
    bus8.a = av; bus8.b = bv; bus8.b_in = bi; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0; bus8.a = ~av; bus8.b = ~bv; bus8.b_in = ~bi;
  endtask

  task automatic start1(input logic av, input logic bv, input logic bi);
    @(negedge clk);
    bus1.a = av; bus1.b = bv; bus1.b_in = bi; bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0; bus1.a = ~av; bus1.b = ~bv; bus1.b_in = ~bi;
  endtask

  // Edges after the start edge until done is seen; -1 if the bound expires
  task automatic wait_done8(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done1(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus1.done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h11; bus8.b_in = 1'b1;
    bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0; bus1.b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got %b exp 0", bus8.busy); end
    n_checks++; if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got %b exp 0", bus8.done); end
    n_checks++; if (bus8.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff8 got %h exp 00", bus8.diff); end
    n_checks++; if (bus8.b_out !== 1'b0) begin n_fail++; $display("FAIL reset_bout8 got %b exp 0", bus8.b_out); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b exp 0", bus1.busy); end
    n_checks++; if ({bus1.b_out, bus1.diff} !== 2'b00) begin n_fail++; $display("FAIL reset_out1 got %b exp 00", {bus1.b_out, bus1.diff}); end
    @(negedge clk);
    rst = 1'b0;
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy8 got %b exp 0", bus8.busy); end
  endtask

  task automatic test_arith;
    logic [7:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
    logic [7:0] vb [5] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01};
    logic       vi [5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] ed [5] = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'h7E};
    logic       eb [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    int cyc;
    for (int k = 0; k < 5; k++) begin
      start8(va[k], vb[k], vi[k]);
      n_checks++; if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL arith%0d_busy got %b exp 1", k, bus8.busy); end
      wait_done8(cyc);
      n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL arith%0d_latency got %0d exp 8", k, cyc); end
      n_checks++; if (bus8.diff !== ed[k]) begin n_fail++; $display("FAIL arith%0d_diff got %h exp %h", k, bus8.diff, ed[k]); end
      n_checks++; if (bus8.b_out !== eb[k]) begin n_fail++; $display("FAIL arith%0d_bout got %b exp %b", k, bus8.b_out, eb[k]); end
      @(posedge clk);
      #1;
      n_checks++; if ({bus8.done, bus8.busy} !== 2'b00) begin n_fail++; $display("FAIL arith%0d_after got done/busy %b exp 00", k, {bus8.done, bus8.busy}); end
      n_checks++; if (bus8.diff !== ed[k]) begin n_fail++; $display("FAIL arith%0d_hold got %h exp %h", k, bus8.diff, ed[k]); end
    end
  endtask

  // Previous result is 0x7E; a second start mid-SHIFT must be ignored
  task automatic test_start_while_busy;
    int first;
    int strobes;
    first = -1;
    strobes = 0;
    start8(8'h05, 8'h03, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        strobes++;
        if (first < 0) first = i;
      end
      if (i == 3) begin
        n_checks++; if (bus8.diff !== 8'h7E) begin n_fail++; $display("FAIL busy_hold_diff got %h exp 7e", bus8.diff); end
        bus8.start = 1'b1; bus8.a = 8'h03; bus8.b = 8'h05; bus8.b_in = 1'b1;
      end
      if (i == 4) bus8.start = 1'b0;
    end
    n_checks++; if (strobes !== 1) begin n_fail++; $display("FAIL busy_strobes got %0d exp 1", strobes); end
    n_checks++; if (first !== 8) begin n_fail++; $display("FAIL busy_latency got %0d exp 8", first); end
    n_checks++; if (bus8.diff !== 8'h02) begin n_fail++; $display("FAIL busy_diff got %h exp 02", bus8.diff); end
    n_checks++; if (bus8.b_out !== 1'b0) begin n_fail++; $display("FAIL busy_bout got %b exp 0", bus8.b_out); end
    n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b exp 0", bus8.busy); end
  endtask

  task automatic test_reset_mid_shift;
    int strobes;
    int cyc;
    strobes = 0;
    start8(8'hFF, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b exp 1", bus8.busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", bus8.busy); end
    n_checks++; if (bus8.diff !== 8'h00) begin n_fail++; $display("FAIL rmid_diff got %h exp 00", bus8.diff); end
    n_checks++; if (bus8.b_out !== 1'b0) begin n_fail++; $display("FAIL rmid_bout got %b exp 0", bus8.b_out); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) strobes++;
    end
    n_checks++; if (strobes !== 0) begin n_fail++; $display("FAIL rmid_strobes got %0d exp 0", strobes); end
    start8(8'h10, 8'h01, 1'b0);
    wait_done8(cyc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL rmid_restart_latency got %0d exp 8", cyc); end
    n_checks++; if ({bus8.b_out, bus8.diff} !== 9'h00F) begin n_fail++; $display("FAIL rmid_restart_result got %h exp 00f", {bus8.b_out, bus8.diff}); end
  endtask

  task automatic test_width1;
    logic [1:0] tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    logic [2:0] v;
    int cyc;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      start1(v[2], v[1], v[0]);
      wait_done1(cyc);
      n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL w1_%0d_latency got %0d exp 1", k, cyc); end
      n_checks++; if ({bus1.b_out, bus1.diff} !== tbl[k]) begin n_fail++; $display("FAIL w1_%0d_result got %b exp %b", k, {bus1.b_out, bus1.diff}, tbl[k]); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.b_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.b_in = 1'b0;
    test_reset;
    test_arith;
    test_start_while_busy;
    test_reset_mid_shift;
    test_width1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
